// File: rtl/nv_demux2_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : nv_demux2_pipe
//  Function : 1-to-2 valid/ready stream demultiplexer with packet-locked
//             routing, one registered pipe stage per output and per-output
//             saturating beat counters.
//  Revision : 1.0  initial release
// ============================================================================
module nv_demux2_pipe #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [DW-1:0]    in_pd,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             out0_pvld,
  input  logic             out0_prdy,
  output logic [DW-1:0]    out0_pd,
  output logic             out0_last,
  output logic             out1_pvld,
  input  logic             out1_prdy,
  output logic [DW-1:0]    out1_pd,
  output logic             out1_last,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] out0_cnt,
  output logic [CNT_W-1:0] out1_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             lock_sel_q, lock_sel_d;

  logic             w_tgt;
  logic             w_accept;
  logic [1:0]       w_rdy;
  logic [1:0]       w_pvld;
  logic [1:0]       w_last;
  logic [DW-1:0]    w_pd  [2];
  logic [CNT_W-1:0] w_cnt [2];

  assign w_rdy = {out1_prdy, out0_prdy};

  // Target selection and input acceptance; only the target stage can stall the input.
  always_comb begin
    w_tgt    = (state_q == ST_BUSY) ? lock_sel_q : in_sel;
    in_prdy  = !w_pvld[w_tgt] || w_rdy[w_tgt];
    w_accept = in_pvld && in_prdy;
  end

  // Packet lock: a non-last first beat locks the route until the last beat passes.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && !in_last) begin
          state_d    = ST_BUSY;
          lock_sel_d = in_sel;
        end
      end
      ST_BUSY: begin
        if (w_accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Routing state register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  genvar g;
  for (g = 0; g < 2; g++) begin : g_out
    logic             pvld_q;
    logic             last_q;
    logic [DW-1:0]    pd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_load;
    logic             w_pop;

    assign w_load = w_accept && (w_tgt == 1'(g));
    assign w_pop  = pvld_q && w_rdy[g];

    // Output pipe stage: load wins over pop, data only changes on load.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
        pvld_q <= 1'b0;
        last_q <= 1'b0;
        pd_q   <= '0;
      end else if (w_load) begin
        pvld_q <= 1'b1;
        last_q <= in_last;
        pd_q   <= in_pd;
      end else if (w_pop) begin
        pvld_q <= 1'b0;
      end
    end

    // Delivered-beat counter: clear has priority, increment saturates.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (w_pop && (cnt_q != c_CNT_MAX)) begin
        cnt_q <= cnt_q + c_CNT_ONE;
      end
    end

    assign w_pvld[g] = pvld_q;
    assign w_last[g] = last_q;
    assign w_pd[g]   = pd_q;
    assign w_cnt[g]  = cnt_q;
  end

  assign out0_pvld = w_pvld[0];
  assign out0_last = w_last[0];
  assign out0_pd   = w_pd[0];
  assign out0_cnt  = w_cnt[0];
  assign out1_pvld = w_pvld[1];
  assign out1_last = w_last[1];
  assign out1_pd   = w_pd[1];
  assign out1_cnt  = w_cnt[1];

endmodule
`default_nettype wire
